// File: rtl/id_pkg.sv
// Shared decode-stage definitions: RV32 base opcodes, the bubble encoding and
// the helpers that say which source registers an opcode actually reads.
package id_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_INST = 32'h0;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/id_regfile_nbyp.sv
// Register array with one write port and one read port resolved through
// NBYP prioritised bypass slots (slot 0 wins) and writeback write-through.
module id_regfile_nbyp
    import id_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NBYP = 2,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        wr_idx,
    input  logic [XLEN-1:0]      wr_data,
    input  logic [AW-1:0]        rd_idx,
    input  logic [NBYP-1:0]      byp_valid,
    input  logic [NBYP*AW-1:0]   byp_rd,
    input  logic [NBYP*XLEN-1:0] byp_data,
    output logic [XLEN-1:0]      rd_data
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wr_idx != '0)) begin
            regs[wr_idx] <= wr_data;
        end
    end

    // Later assignments override earlier ones, so walk from oldest to youngest.
    always_comb begin
        rd_data = regs[rd_idx];
        if (we && (wr_idx == rd_idx)) begin
            rd_data = wr_data;
        end
        for (int i = int'(NBYP) - 1; i >= 0; i--) begin
            if (byp_valid[i] && (byp_rd[i*AW +: AW] == rd_idx)) begin
                rd_data = byp_data[i*XLEN +: XLEN];
            end
        end
        if (rd_idx == '0) begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-operand stage: IF/ID holding register with stall/flush, operand
// resolution through the bypass network, load-use scoreboard and branch compare.
module id_operand_stage
    import id_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned NBYP     = 2,
    parameter int unsigned LOAD_LAT = 1,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    input  logic [31:0]          if_inst,
    input  logic [XLEN-1:0]      if_pc,
    input  logic                 id_stall,
    input  logic                 id_flush,
    input  logic [NBYP-1:0]      byp_valid,
    input  logic [NBYP*AW-1:0]   byp_rd,
    input  logic [NBYP*XLEN-1:0] byp_data,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 ex_load_valid,
    input  logic [AW-1:0]        ex_load_rd,
    output logic                 id_valid,
    output logic [31:0]          id_inst,
    output logic [XLEN-1:0]      id_pc,
    output logic [AW-1:0]        rs1_idx,
    output logic [AW-1:0]        rs2_idx,
    output logic [AW-1:0]        rd_idx,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic                 load_use_stall,
    output logic                 br_eq,
    output logic                 br_lt,
    output logic                 br_ltu
);

    logic [LOAD_LAT-1:0] sb_valid;
    logic [AW-1:0]       sb_rd [LOAD_LAT];
    logic                sb_hit;
    logic [6:0]          opcode;

    // Flush outranks every hold source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
            id_pc    <= '0;
        end else if (id_flush) begin
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
        end else if (!(id_stall || load_use_stall)) begin
            id_valid <= if_valid;
            id_inst  <= if_valid ? if_inst : NOP_INST;
            id_pc    <= if_pc;
        end
    end

    assign opcode  = id_inst[6:0];
    assign rs1_idx = id_inst[15 +: AW];
    assign rs2_idx = id_inst[20 +: AW];
    assign rd_idx  = id_inst[7 +: AW];

    // Loads already in EX stay tracked across a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(LOAD_LAT); k++) begin
                sb_valid[k] <= 1'b0;
                sb_rd[k]    <= '0;
            end
        end else begin
            sb_valid[0] <= ex_load_valid && (ex_load_rd != '0);
            sb_rd[0]    <= ex_load_rd;
            for (int k = 1; k < int'(LOAD_LAT); k++) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_rd[k]    <= sb_rd[k-1];
            end
        end
    end

    always_comb begin
        sb_hit = 1'b0;
        for (int k = 0; k < int'(LOAD_LAT); k++) begin
            if (sb_valid[k] && ((uses_rs1(opcode) && (sb_rd[k] == rs1_idx)) ||
                                (uses_rs2(opcode) && (sb_rd[k] == rs2_idx)))) begin
                sb_hit = 1'b1;
            end
        end
        load_use_stall = id_valid && sb_hit;
    end

    id_regfile_nbyp #(.XLEN(XLEN), .NREG(NREG), .NBYP(NBYP)) u_rf_rs1 (
        .clk       (clk),
        .rst       (rst),
        .we        (wb_we),
        .wr_idx    (wb_rd),
        .wr_data   (wb_data),
        .rd_idx    (rs1_idx),
        .byp_valid (byp_valid),
        .byp_rd    (byp_rd),
        .byp_data  (byp_data),
        .rd_data   (rs1_data)
    );

    id_regfile_nbyp #(.XLEN(XLEN), .NREG(NREG), .NBYP(NBYP)) u_rf_rs2 (
        .clk       (clk),
        .rst       (rst),
        .we        (wb_we),
        .wr_idx    (wb_rd),
        .wr_data   (wb_data),
        .rd_idx    (rs2_idx),
        .byp_valid (byp_valid),
        .byp_rd    (byp_rd),
        .byp_data  (byp_data),
        .rd_data   (rs2_data)
    );

    assign br_eq  = (rs1_data == rs2_data);
    assign br_lt  = ($signed(rs1_data) < $signed(rs2_data));
    assign br_ltu = (rs1_data < rs2_data);

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: bypass priority, x0, load-use stall,
// flush over stall with scoreboard retention, and async reset mid-stall.
module tb_id_operand_stage;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NBYP = 2;

    localparam logic [31:0] ADD_X1_X5_X6  = 32'h006280B3;
    localparam logic [31:0] ADD_X1_X0_X6  = 32'h006000B3;
    localparam logic [31:0] ADD_X3_X7_X2  = 32'h002381B3;
    localparam logic [31:0] ADDI_X3_X8_7  = 32'h00740193;
    localparam logic [31:0] LUI_X7_38     = 32'h000383B7;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 if_valid;
    logic [31:0]          if_inst;
    logic [XLEN-1:0]      if_pc;
    logic                 id_stall;
    logic                 id_flush;
    logic [NBYP-1:0]      byp_valid;
    logic [NBYP*AW-1:0]   byp_rd;
    logic [NBYP*XLEN-1:0] byp_data;
    logic                 wb_we;
    logic [AW-1:0]        wb_rd;
    logic [XLEN-1:0]      wb_data;
    logic                 ex_load_valid;
    logic [AW-1:0]        ex_load_rd;

    logic            id_valid, load_use_stall, br_eq, br_lt, br_ltu;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_pc, rs1_data, rs2_data;
    logic [AW-1:0]   rs1_idx, rs2_idx, rd_idx;

    logic            d2_id_valid, d2_load_use_stall, d2_br_eq, d2_br_lt, d2_br_ltu;
    logic [31:0]     d2_id_inst;
    logic [XLEN-1:0] d2_id_pc, d2_rs1_data, d2_rs2_data;
    logic [AW-1:0]   d2_rs1_idx, d2_rs2_idx, d2_rd_idx;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_operand_stage #(.XLEN(XLEN), .NREG(32), .NBYP(NBYP), .LOAD_LAT(1)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_stall(id_stall), .id_flush(id_flush), .byp_valid(byp_valid), .byp_rd(byp_rd),
        .byp_data(byp_data), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .id_valid(id_valid),
        .id_inst(id_inst), .id_pc(id_pc), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rd_idx(rd_idx), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .load_use_stall(load_use_stall), .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu)
    );

    id_operand_stage #(.XLEN(XLEN), .NREG(32), .NBYP(NBYP), .LOAD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_stall(id_stall), .id_flush(id_flush), .byp_valid(byp_valid), .byp_rd(byp_rd),
        .byp_data(byp_data), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .id_valid(d2_id_valid),
        .id_inst(d2_id_inst), .id_pc(d2_id_pc), .rs1_idx(d2_rs1_idx), .rs2_idx(d2_rs2_idx),
        .rd_idx(d2_rd_idx), .rs1_data(d2_rs1_data), .rs2_data(d2_rs2_data),
        .load_use_stall(d2_load_use_stall), .br_eq(d2_br_eq), .br_lt(d2_br_lt),
        .br_ltu(d2_br_ltu)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_valid = 1'b0; if_inst = '0; if_pc = '0;
        id_stall = 1'b0; id_flush = 1'b0;
        byp_valid = '0; byp_rd = '0; byp_data = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        ex_load_valid = 1'b0; ex_load_rd = '0;
        #12;
        check("rst_valid", 32'(id_valid), 32'h0);
        check("rst_inst", id_inst, 32'h0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_lus", 32'(load_use_stall), 32'h0);
        rst = 1'b0;

        // capture ADD x1,x5,x6 while writing x5=0x11
        if_valid = 1'b1; if_inst = ADD_X1_X5_X6; if_pc = 32'h100;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h11;
        tick();
        check("cap_valid", 32'(id_valid), 32'h1);
        check("cap_inst", id_inst, ADD_X1_X5_X6);
        check("cap_pc", id_pc, 32'h100);
        check("rs1_idx", 32'(rs1_idx), 32'd5);
        check("rs2_idx", 32'(rs2_idx), 32'd6);
        check("rd_idx", 32'(rd_idx), 32'd1);
        wb_we = 1'b0; if_valid = 1'b0; id_stall = 1'b1;
        #1 check("arr_x5", rs1_data, 32'h11);

        // bypass priority
        byp_valid = 2'b11; byp_rd = {5'd5, 5'd5}; byp_data = {32'hBB, 32'hAA};
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hCC;
        #1 check("byp0_wins", rs1_data, 32'hAA);
        byp_valid = 2'b10;
        #1 check("byp1_wins", rs1_data, 32'hBB);
        byp_valid = 2'b00;
        #1 check("wb_thru", rs1_data, 32'hCC);
        tick();
        wb_we = 1'b0;
        #1 check("arr_x5_cc", rs1_data, 32'hCC);
        check("stall_hold", id_inst, ADD_X1_X5_X6);

        // branch compare via bypasses on x5 and x6
        byp_valid = 2'b11; byp_rd = {5'd6, 5'd5}; byp_data = {32'h1, 32'hFFFF_FFFF};
        #1 check("rs2_byp", rs2_data, 32'h1);
        check("neg_eq", 32'(br_eq), 32'h0);
        check("neg_lt", 32'(br_lt), 32'h1);
        check("neg_ltu", 32'(br_ltu), 32'h0);
        byp_data = {32'h1, 32'h1};
        #1 check("eq_eq", 32'(br_eq), 32'h1);
        check("eq_lt", 32'(br_lt), 32'h0);
        check("eq_ltu", 32'(br_ltu), 32'h0);
        byp_valid = 2'b00;

        // x0 ignores writeback and bypass
        id_stall = 1'b0; if_valid = 1'b1; if_inst = ADD_X1_X0_X6; if_pc = 32'h104;
        tick();
        id_stall = 1'b1;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        byp_valid = 2'b01; byp_rd = {5'd0, 5'd0}; byp_data = {32'h0, 32'h5};
        #1 check("x0_byp", rs1_data, 32'h0);
        tick();
        wb_we = 1'b0; byp_valid = 2'b00;
        #1 check("x0_arr", rs1_data, 32'h0);

        // load-use: ADD x3,x7,x2 captured with load to x7 entering EX
        id_stall = 1'b0; if_inst = ADD_X3_X7_X2; if_pc = 32'h108;
        ex_load_valid = 1'b1; ex_load_rd = 5'd7;
        tick();
        ex_load_valid = 1'b0; if_inst = ADDI_X3_X8_7; if_pc = 32'h10C;
        #1 check("lu_stall", 32'(load_use_stall), 32'h1);
        check("lu_inst", id_inst, ADD_X3_X7_X2);
        tick();
        check("lu_clear", 32'(load_use_stall), 32'h0);
        check("lu_held", id_inst, ADD_X3_X7_X2);
        check("lu_held_pc", id_pc, 32'h108);
        tick();
        check("lu_adv", id_inst, ADDI_X3_X8_7);
        check("lu_adv_pc", id_pc, 32'h10C);

        // non-use: LUI x7 and ADDI with rs2 field = 7
        if_inst = LUI_X7_38; ex_load_valid = 1'b1; ex_load_rd = 5'd7;
        tick();
        ex_load_valid = 1'b0;
        check("lui_inst", id_inst, LUI_X7_38);
        check("lui_nostall", 32'(load_use_stall), 32'h0);
        if_inst = ADDI_X3_X8_7; ex_load_valid = 1'b1;
        tick();
        ex_load_valid = 1'b0;
        check("addi_inst", id_inst, ADDI_X3_X8_7);
        check("addi_nostall", 32'(load_use_stall), 32'h0);

        // flush beats stall; scoreboard survives the flush
        id_stall = 1'b1; id_flush = 1'b1; ex_load_valid = 1'b1; ex_load_rd = 5'd7;
        tick();
        check("fl_valid", 32'(id_valid), 32'h0);
        check("fl_inst", id_inst, 32'h0);
        check("fl_valid2", 32'(d2_id_valid), 32'h0);
        check("fl_inst2", d2_id_inst, 32'h0);
        id_stall = 1'b0; id_flush = 1'b0; ex_load_valid = 1'b0;
        if_inst = ADD_X3_X7_X2; if_pc = 32'h110;
        tick();
        check("fl_lat1_stall", 32'(load_use_stall), 32'h0);
        check("fl_lat2_stall", 32'(d2_load_use_stall), 32'h1);
        check("fl_lat2_inst", d2_id_inst, ADD_X3_X7_X2);

        // async reset mid-stall
        id_stall = 1'b1; ex_load_valid = 1'b1; ex_load_rd = 5'd7;
        tick();
        ex_load_valid = 1'b0;
        #1 check("pre_rst_stall", 32'(load_use_stall), 32'h1);
        #2 rst = 1'b1;
        #1 check("arst_valid", 32'(id_valid), 32'h0);
        check("arst_inst", id_inst, 32'h0);
        check("arst_stall", 32'(load_use_stall), 32'h0);
        check("arst_rs1", rs1_data, 32'h0);
        check("arst_rs2", rs2_data, 32'h0);
        check("arst_eq", 32'(br_eq), 32'h1);
        #1 rst = 1'b0;
        id_stall = 1'b0; if_valid = 1'b1; if_inst = ADD_X1_X5_X6; if_pc = 32'h200;
        tick();
        check("arst_x5_clr", rs1_data, 32'h0);
        check("arst_cap", id_inst, ADD_X1_X5_X6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
